// File: rtl/kovacs_pkg.sv
// Shared encodings for the Kovacs protocol sequencer: source selects,
// DAC indicator levels and the controller state enum.
package kovacs_pkg;

    typedef enum logic [1:0] {
        SEL_LOW  = 2'd0,
        SEL_RESC = 2'd1,
        SEL_RAW  = 2'd2,
        SEL_LOW2 = 2'd3
    } sel_e;

    localparam logic [13:0] IND_LOW  = 14'd0;
    localparam logic [13:0] IND_RESC = 14'd4096;
    localparam logic [13:0] IND_RAW  = 14'd8191;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic [13:0] sel_indicator(input sel_e sel);
        case (sel)
            SEL_RESC: return IND_RESC;
            SEL_RAW:  return IND_RAW;
            default:  return IND_LOW;
        endcase
    endfunction

endpackage

// File: rtl/kovacs_phase_table.sv
// Double-buffered phase table: writes land in the pending bank, a commit
// strobe copies pending into the active bank that the sequencer runs from.
module kovacs_phase_table
    import kovacs_pkg::*;
#(
    parameter int NPHASE = 4,
    parameter int DW     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [2:0]    wr_addr_i,
    input  logic [DW-1:0] wr_dur_i,
    input  logic [1:0]    wr_sel_i,
    input  logic          commit_i,
    input  logic [2:0]    cur_idx_i,
    output logic [DW-1:0] cur_dur_o,
    input  logic [2:0]    nxt_idx_i,
    output logic [1:0]    nxt_sel_o,
    output logic          pending_valid_o
);

    localparam int          AW  = (NPHASE > 1) ? $clog2(NPHASE) : 1;
    localparam logic [3:0]  NPH = 4'(NPHASE);

    logic [DW-1:0] dur_pend_q [NPHASE];
    logic [DW-1:0] dur_act_q  [NPHASE];
    sel_e          sel_pend_q [NPHASE];
    sel_e          sel_act_q  [NPHASE];
    logic          pend_valid_q;

    logic wr_ok;
    logic cur_ok;
    logic nxt_ok;

    assign wr_ok  = wr_en_i && ({1'b0, wr_addr_i} < NPH);
    assign cur_ok = {1'b0, cur_idx_i} < NPH;
    assign nxt_ok = {1'b0, nxt_idx_i} < NPH;

    assign cur_dur_o = cur_ok ? dur_act_q[cur_idx_i[AW-1:0]] : '0;

    // A committing cycle already exposes the pending select so the output
    // mux can follow the new table on the very edge phase 0 is entered.
    always_comb begin
        nxt_sel_o = SEL_LOW;
        if (nxt_ok) begin
            nxt_sel_o = commit_i ? sel_pend_q[nxt_idx_i[AW-1:0]]
                                 : sel_act_q[nxt_idx_i[AW-1:0]];
        end
    end

    assign pending_valid_o = pend_valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NPHASE; i++) begin
                dur_pend_q[i] <= '0;
                dur_act_q[i]  <= '0;
                sel_pend_q[i] <= SEL_LOW;
                sel_act_q[i]  <= SEL_LOW;
            end
            pend_valid_q <= 1'b0;
        end else begin
            if (commit_i) begin
                for (int i = 0; i < NPHASE; i++) begin
                    dur_act_q[i] <= dur_pend_q[i];
                    sel_act_q[i] <= sel_pend_q[i];
                end
                pend_valid_q <= 1'b0;
            end
            // Write after commit: a coincident write misses this commit but keeps valid set.
            if (wr_ok) begin
                dur_pend_q[wr_addr_i[AW-1:0]] <= wr_dur_i;
                sel_pend_q[wr_addr_i[AW-1:0]] <= sel_e'(wr_sel_i);
                pend_valid_q                  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/kovacs_protocol_sequencer.sv
// Phase sequencer for the Kovacs feedback protocols: steps through a
// programmable phase table and drives the 14-bit DAC data mux and indicator.
//
// state   | meaning
// ST_IDLE | stopped, mux forced to low source, waiting for start_i
// ST_RUN  | stepping phases, counting completed protocol cycles
module kovacs_protocol_sequencer
    import kovacs_pkg::*;
#(
    parameter int NPHASE = 4,
    parameter int DW     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic [2:0]    nphase_i,
    input  logic [DW-1:0] ncycles_i,
    input  logic          wr_en_i,
    input  logic [2:0]    wr_addr_i,
    input  logic [DW-1:0] wr_dur_i,
    input  logic [1:0]    wr_sel_i,
    input  logic [15:0]   data_i,
    input  logic [15:0]   data_rescaled_i,
    input  logic [15:0]   data_low_i,
    output logic [13:0]   data_o,
    output logic [13:0]   indicator_o,
    output logic [2:0]    phase_o,
    output logic          phase_start_o,
    output logic          cycle_done_o,
    output logic          done_o,
    output logic          busy_o,
    output logic [DW-1:0] cycles_o
);

    localparam logic [3:0] NPH = 4'(NPHASE);

    state_e        state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [2:0]    nlast_q, nlast_in;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] cycles_q, cycles_d;
    logic [DW-1:0] ncycles_q;
    logic          pstart_q, pstart_d;
    logic          cdone_q, cdone_d;
    logic          done_q, done_d;
    logic          busy_q;
    logic [13:0]   data_q, data_d;
    logic [13:0]   ind_q, ind_d;

    logic          commit;
    logic          start_go;
    logic          pend_valid;
    logic [DW-1:0] cur_dur;
    logic [DW-1:0] dur_m1;
    logic [1:0]    nxt_sel;
    sel_e          sel_d;
    logic          phase_end;
    logic [DW-1:0] cycles_inc;
    logic          count_hit;

    kovacs_phase_table #(
        .NPHASE (NPHASE),
        .DW     (DW)
    ) u_table (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .wr_en_i         (wr_en_i),
        .wr_addr_i       (wr_addr_i),
        .wr_dur_i        (wr_dur_i),
        .wr_sel_i        (wr_sel_i),
        .commit_i        (commit),
        .cur_idx_i       (phase_q),
        .cur_dur_o       (cur_dur),
        .nxt_idx_i       (phase_d),
        .nxt_sel_o       (nxt_sel),
        .pending_valid_o (pend_valid)
    );

    always_comb begin
        if (nphase_i == 3'd0) begin
            nlast_in = 3'd0;
        end else if ({1'b0, nphase_i} > NPH) begin
            nlast_in = 3'(NPHASE - 1);
        end else begin
            nlast_in = nphase_i - 3'd1;
        end
    end

    // A zero duration behaves as one cycle.
    assign dur_m1     = (cur_dur == '0) ? '0 : cur_dur - DW'(1);
    assign phase_end  = (cnt_q == dur_m1);
    assign cycles_inc = cycles_q + DW'(1);
    assign count_hit  = (ncycles_q != '0) && (cycles_inc == ncycles_q);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        pstart_d = 1'b0;
        cdone_d  = 1'b0;
        done_d   = 1'b0;
        commit   = 1'b0;
        start_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    state_d  = ST_RUN;
                    start_go = 1'b1;
                    commit   = 1'b1;
                    phase_d  = '0;
                    cnt_d    = '0;
                    cycles_d = '0;
                    pstart_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    cnt_d   = '0;
                end else if (!phase_end) begin
                    cnt_d = cnt_q + DW'(1);
                end else begin
                    cnt_d = '0;
                    if (phase_q != nlast_q) begin
                        phase_d  = phase_q + 3'd1;
                        pstart_d = 1'b1;
                    end else begin
                        phase_d  = '0;
                        cdone_d  = 1'b1;
                        cycles_d = cycles_inc;
                        commit   = pend_valid;
                        if (count_hit) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            pstart_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mux follows the next-state select so data and phase change on the same edge.
    always_comb begin
        sel_d = (state_d == ST_RUN) ? sel_e'(nxt_sel) : SEL_LOW;
        case (sel_d)
            SEL_RESC: data_d = data_rescaled_i[15:2];
            SEL_RAW:  data_d = data_i[15:2];
            default:  data_d = data_low_i[15:2];
        endcase
        ind_d = sel_indicator(sel_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            nlast_q   <= '0;
            cnt_q     <= '0;
            cycles_q  <= '0;
            ncycles_q <= '0;
            pstart_q  <= 1'b0;
            cdone_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            ind_q     <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            pstart_q <= pstart_d;
            cdone_q  <= cdone_d;
            done_q   <= done_d;
            busy_q   <= (state_d == ST_RUN);
            data_q   <= data_d;
            ind_q    <= ind_d;
            if (start_go) begin
                ncycles_q <= ncycles_i;
                nlast_q   <= nlast_in;
            end
        end
    end

    assign data_o        = data_q;
    assign indicator_o   = ind_q;
    assign phase_o       = phase_q;
    assign phase_start_o = pstart_q;
    assign cycle_done_o  = cdone_q;
    assign done_o        = done_q;
    assign busy_o        = busy_q;
    assign cycles_o      = cycles_q;

endmodule

// File: tb/tb_kovacs_protocol_sequencer.sv
// Bench for kovacs_protocol_sequencer: directed protocol scenarios plus random
// traffic, all compared cycle by cycle against a countdown-based reference model.
module tb_kovacs_protocol_sequencer;

    localparam int NPHASE = 4;
    localparam int DW     = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i, stop_i, wr_en_i;
    logic [2:0]    nphase_i, wr_addr_i;
    logic [DW-1:0] ncycles_i, wr_dur_i;
    logic [1:0]    wr_sel_i;
    logic [15:0]   data_i, data_rescaled_i, data_low_i;
    logic [13:0]   data_o, indicator_o;
    logic [2:0]    phase_o;
    logic          phase_start_o, cycle_done_o, done_o, busy_o;
    logic [DW-1:0] cycles_o;

    always #5 clk_i = ~clk_i;

    kovacs_protocol_sequencer #(.NPHASE(NPHASE), .DW(DW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .nphase_i        (nphase_i),
        .ncycles_i       (ncycles_i),
        .wr_en_i         (wr_en_i),
        .wr_addr_i       (wr_addr_i),
        .wr_dur_i        (wr_dur_i),
        .wr_sel_i        (wr_sel_i),
        .data_i          (data_i),
        .data_rescaled_i (data_rescaled_i),
        .data_low_i      (data_low_i),
        .data_o          (data_o),
        .indicator_o     (indicator_o),
        .phase_o         (phase_o),
        .phase_start_o   (phase_start_o),
        .cycle_done_o    (cycle_done_o),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .cycles_o        (cycles_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int tick  = 0;

    // Reference model: phase progress kept as "cycles left in this phase".
    bit          m_run, m_pv, m_pstart, m_cdone, m_done;
    int          m_phase, m_nph;
    logic [31:0] m_left, m_cyc, m_ncyc;
    logic [31:0] pend_dur [8];
    logic [31:0] act_dur  [8];
    int          pend_sel [8];
    int          act_sel  [8];
    logic [13:0] m_data, m_ind;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] eff(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pv = 0; m_pstart = 0; m_cdone = 0; m_done = 0;
        m_phase = 0; m_nph = 1; m_left = 0; m_cyc = 0; m_ncyc = 0;
        m_data = '0; m_ind = '0;
        for (int i = 0; i < 8; i++) begin
            pend_dur[i] = 0; act_dur[i] = 0; pend_sel[i] = 0; act_sel[i] = 0;
        end
    endtask

    task automatic model_edge();
        int sel;
        m_pstart = 0; m_cdone = 0; m_done = 0;
        if (!m_run) begin
            if (start_i && !stop_i) begin
                m_run  = 1;
                m_ncyc = ncycles_i;
                m_nph  = (nphase_i == 0) ? 1 : ((int'(nphase_i) > NPHASE) ? NPHASE : int'(nphase_i));
                act_dur = pend_dur; act_sel = pend_sel; m_pv = 0;
                m_phase = 0; m_left = eff(act_dur[0]); m_cyc = 0; m_pstart = 1;
            end
        end else if (stop_i) begin
            m_run = 0; m_phase = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_phase == m_nph - 1) begin
                    m_cdone = 1;
                    m_cyc   = m_cyc + 1;
                    if (m_pv) begin
                        act_dur = pend_dur; act_sel = pend_sel; m_pv = 0;
                    end
                    m_phase = 0;
                    if (m_ncyc != 0 && m_cyc == m_ncyc) begin
                        m_run = 0; m_done = 1;
                    end else begin
                        m_left = eff(act_dur[0]); m_pstart = 1;
                    end
                end else begin
                    m_phase = m_phase + 1;
                    m_left  = eff(act_dur[m_phase]);
                    m_pstart = 1;
                end
            end
        end
        if (wr_en_i && int'(wr_addr_i) < NPHASE) begin
            pend_dur[wr_addr_i] = wr_dur_i;
            pend_sel[wr_addr_i] = int'(wr_sel_i);
            m_pv = 1;
        end
        sel = m_run ? act_sel[m_phase] : 0;
        case (sel)
            1:       begin m_data = data_rescaled_i[15:2]; m_ind = 14'd4096; end
            2:       begin m_data = data_i[15:2];          m_ind = 14'd8191; end
            default: begin m_data = data_low_i[15:2];      m_ind = 14'd0;    end
        endcase
    endtask

    task automatic check_outs();
        chk("busy",       32'(busy_o),        32'(m_run));
        chk("phase",      32'(phase_o),       32'(m_phase));
        chk("phase_start",32'(phase_start_o), 32'(m_pstart));
        chk("cycle_done", 32'(cycle_done_o),  32'(m_cdone));
        chk("done",       32'(done_o),        32'(m_done));
        chk("cycles",     cycles_o,           m_cyc);
        chk("data",       32'(data_o),        32'(m_data));
        chk("indicator",  32'(indicator_o),   32'(m_ind));
    endtask

    task automatic step();
        data_i          = 16'($urandom);
        data_rescaled_i = 16'($urandom);
        data_low_i      = 16'($urandom);
        model_edge();
        @(posedge clk_i);
        #1;
        tick++;
        check_outs();
        start_i = 0; stop_i = 0; wr_en_i = 0;
    endtask

    task automatic wr(input int addr, input int dur, input int sel);
        wr_en_i = 1; wr_addr_i = 3'(addr); wr_dur_i = 32'(dur); wr_sel_i = 2'(sel);
        step();
    endtask

    task automatic check_reset_outs();
        chk("rst_data",   32'(data_o),        32'd0);
        chk("rst_ind",    32'(indicator_o),   32'd0);
        chk("rst_phase",  32'(phase_o),       32'd0);
        chk("rst_pstart", 32'(phase_start_o), 32'd0);
        chk("rst_cdone",  32'(cycle_done_o),  32'd0);
        chk("rst_done",   32'(done_o),        32'd0);
        chk("rst_busy",   32'(busy_o),        32'd0);
        chk("rst_cycles", cycles_o,           32'd0);
    endtask

    function automatic bit at_cycle_end();
        return m_run && (m_phase == m_nph - 1) && (m_left == 1);
    endfunction

    initial begin
        int t0, first_cd, npst, guard;
        rst_i = 1; start_i = 0; stop_i = 0; wr_en_i = 0;
        nphase_i = 0; ncycles_i = 0; wr_addr_i = 0; wr_dur_i = 0; wr_sel_i = 0;
        data_i = 0; data_rescaled_i = 0; data_low_i = 0;
        model_reset();
        #1;
        check_reset_outs();
        @(posedge clk_i); #2;
        rst_i = 0;
        step();

        // 3-phase table 4/2/3, two cycles
        wr(0, 4, 0); wr(1, 2, 2); wr(2, 3, 1);
        nphase_i = 3; ncycles_i = 2; start_i = 1;
        step();
        t0 = tick; first_cd = -1; guard = 0;
        while (!done_o && guard < 200) begin
            step(); guard++;
            if (cycle_done_o && first_cd < 0) first_cd = tick - t0;
        end
        chk("t2_first_cycle_done", 32'(first_cd), 32'd9);
        chk("t2_done_at", 32'(tick - t0), 32'd18);
        chk("t2_cycles", cycles_o, 32'd2);
        chk("t2_busy_after", 32'(busy_o), 32'd0);

        // asynchronous reset mid-run
        start_i = 1; step(); step(); step(); step();
        rst_i = 1;
        #1;
        check_reset_outs();
        model_reset();
        #10;
        rst_i = 0;
        step();
        chk("rst_release_low", 32'(data_o), 32'(data_low_i[15:2]));

        // zero and one-cycle durations
        wr(0, 0, 1); wr(1, 1, 2);
        nphase_i = 2; ncycles_i = 3; start_i = 1;
        step();
        t0 = tick; npst = 1; guard = 0;
        while (!done_o && guard < 100) begin
            step(); guard++;
            if (phase_start_o) npst++;
        end
        chk("t3_done_at", 32'(tick - t0), 32'd6);
        chk("t3_phase_starts", 32'(npst), 32'd6);

        // double-buffered updates, including a write on the commit edge
        wr(0, 4, 0); wr(1, 2, 2); wr(2, 3, 1);
        nphase_i = 3; ncycles_i = 4; start_i = 1;
        step();
        t0 = tick;
        step();
        wr(1, 10, 2);
        guard = 0;
        while (!at_cycle_end() && guard < 100) begin step(); guard++; end
        step();
        wr(0, 4, 0);
        guard = 0;
        while (!at_cycle_end() && guard < 100) begin step(); guard++; end
        wr(2, 5, 1);
        guard = 0;
        while (!done_o && guard < 200) begin step(); guard++; end
        chk("t4_done_at", 32'(tick - t0), 32'd62);
        chk("t4_cycles", cycles_o, 32'd4);

        // start and stop together while idle; stop mid-phase
        start_i = 1; stop_i = 1; step();
        chk("t5_stay_idle", 32'(busy_o), 32'd0);
        start_i = 1; step(); step(); step();
        stop_i = 1; step();
        chk("t5_stop_busy", 32'(busy_o), 32'd0);
        chk("t5_stop_no_done", 32'(done_o), 32'd0);

        // free-running with a start while busy
        wr(0, 1, 1); wr(1, 1, 2);
        nphase_i = 2; ncycles_i = 0; start_i = 1;
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 4) start_i = 1;
            step();
        end
        chk("t6_cycles", cycles_o, 32'd5);
        chk("t6_still_busy", 32'(busy_o), 32'd1);
        stop_i = 1; step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            start_i   = ($urandom_range(0, 15) == 0);
            stop_i    = ($urandom_range(0, 40) == 0);
            nphase_i  = 3'($urandom_range(0, 7));
            ncycles_i = 32'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0) begin
                wr_en_i   = 1;
                wr_addr_i = 3'($urandom_range(0, 7));
                wr_dur_i  = 32'($urandom_range(0, 5));
                wr_sel_i  = 2'($urandom_range(0, 3));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
